// File: rtl/frame_sipo_rx.sv
// Serial-to-parallel configuration frame receiver: hunts for SYNC_WORD, shifts in a 27-bit body, commits it to outputs.
// Latency: outputs update on the edge that samples the last frame bit (33 enabled edges with parity, 32 without).
// Backpressure: none; en gates every register, so en=0 edges freeze the receiver. Optional parity via FRAME_PARITY_EN.
module frame_sipo_rx #(
  parameter logic [4:0] SYNC_WORD = 5'b10110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in,
  output logic       out_sel,
  output logic       clk_sel,
  output logic [4:0] out1,
  output logic [4:0] out2,
  output logic [4:0] out3,
  output logic [4:0] out4,
  output logic [4:0] out5,
  output logic       finished,
  output logic       err,
  output logic       busy
);

  localparam int BODY_BITS = 27;

  // With parity the whole body is held until the parity bit arrives; without it
  // the final body bit goes straight from the input into the committed image.
`ifdef FRAME_PARITY_EN
  localparam int SHADOW_W = BODY_BITS;
`else
  localparam int SHADOW_W = BODY_BITS - 1;
`endif

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                 state_q,  state_d;
  // Only four past bits are stored; the fifth bit of the sync window is the live input.
  logic [3:0]             hist_q,   hist_d;
  // Number of fresh enabled bits seen since the history was last cleared (saturates at 4).
  logic [2:0]             fill_q,   fill_d;
  logic [4:0]             cnt_q,    cnt_d;
  logic [SHADOW_W-1:0]    shadow_q, shadow_d;
  // Committed frame image, laid out out_sel, clk_sel, out1..out5 from MSB down.
  logic [BODY_BITS-1:0]   frame_q,  frame_d;
  logic                   finished_q, finished_d;
  logic                   busy_q,   busy_d;
`ifdef FRAME_PARITY_EN
  logic                   err_q,    err_d;
`endif

  logic [4:0]             sync_window;
  logic                   window_full;

  assign sync_window = {hist_q, in};
  assign window_full = (fill_q >= 3'd4);

  // Next-state logic: hunt for sync, shift the body, then commit (or reject on bad parity).
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    frame_d    = frame_q;
    finished_d = finished_q;
    busy_d     = busy_q;
`ifdef FRAME_PARITY_EN
    err_d      = err_q;
`endif

    if (en) begin
      case (state_q)
        HUNT: begin
          hist_d = sync_window[3:0];
          fill_d = window_full ? 3'd4 : fill_q + 3'd1;
          // A match needs five bits received since the history was cleared,
          // so zeros left over from the clear can never complete a sync word.
          if (window_full && (sync_window == SYNC_WORD)) begin
            state_d = LOAD;
            cnt_d   = 5'd0;
            busy_d  = 1'b1;
            hist_d  = 4'd0;
            fill_d  = 3'd0;
          end
        end

        LOAD: begin
          shadow_d = {shadow_q[SHADOW_W-2:0], in};
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'(BODY_BITS - 1)) begin
`ifdef FRAME_PARITY_EN
            state_d = CHECK;
`else
            frame_d    = {shadow_q, in};
            finished_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = HUNT;
`endif
          end
        end

`ifdef FRAME_PARITY_EN
        CHECK: begin
          // Even parity over body plus parity bit; a bad frame leaves the outputs untouched.
          if ((^shadow_q ^ in) == 1'b0) begin
            frame_d    = shadow_q;
            finished_d = 1'b1;
            err_d      = 1'b0;
          end else begin
            err_d      = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = HUNT;
        end
`endif

        default: begin
          state_d = HUNT;
          hist_d  = 4'd0;
          fill_d  = 3'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; synchronous active-low reset wins over en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      frame_q    <= '0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FRAME_PARITY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
`ifdef FRAME_PARITY_EN
      err_q      <= err_d;
`endif
    end
  end

  assign out_sel  = frame_q[26];
  assign clk_sel  = frame_q[25];
  assign out1     = frame_q[24:20];
  assign out2     = frame_q[19:15];
  assign out3     = frame_q[14:10];
  assign out4     = frame_q[9:5];
  assign out5     = frame_q[4:0];
  assign finished = finished_q;
  assign busy     = busy_q;
`ifdef FRAME_PARITY_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sipo_rx.sv
// Bench for frame_sipo_rx: directed frames with literal expectations plus randomized traffic,
// every cycle compared against a queue-based frame model. Works with or without FRAME_PARITY_EN.
module tb_frame_sipo_rx;

  localparam logic [4:0] SYNC = 5'b10110;
`ifdef FRAME_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 28 : 27;

  logic       clk = 1'b0;
  logic       rst, en, din;
  logic       out_sel, clk_sel, finished, err, busy;
  logic [4:0] out1, out2, out3, out4, out5;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  frame_sipo_rx #(.SYNC_WORD(SYNC)) dut (
    .clk(clk), .rst(rst), .en(en), .in(din),
    .out_sel(out_sel), .clk_sel(clk_sel),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .finished(finished), .err(err), .busy(busy)
  );

  // Behavioural model: a sliding window of the last enabled bits while hunting,
  // a queue of collected frame bits while busy, decoded arithmetically when full.
  bit         m_busy;
  bit         m_hist[$];
  bit         m_body[$];
  logic       m_osel, m_csel, m_fin, m_err;
  logic [4:0] m_o[1:5];

  task automatic model_reset();
    m_busy = 0; m_hist.delete(); m_body.delete();
    m_osel = 0; m_csel = 0; m_fin = 0; m_err = 0;
    for (int k = 1; k <= 5; k++) m_o[k] = 5'd0;
  endtask

  task automatic model_update(input bit r, input bit e, input bit b);
    int v, ones, val;
    if (!r) begin
      model_reset();
    end else if (e) begin
      if (!m_busy) begin
        m_hist.push_back(b);
        if (m_hist.size() > 5) void'(m_hist.pop_front());
        if (m_hist.size() == 5) begin
          v = 0;
          foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
          if (v == int'(SYNC)) begin
            m_busy = 1; m_hist.delete(); m_body.delete();
          end
        end
      end else begin
        m_body.push_back(b);
        if (m_body.size() == NB) begin
          ones = 0;
          foreach (m_body[i]) ones += int'(m_body[i]);
          if (!PAR || (ones % 2 == 0)) begin
            m_osel = m_body[0];
            m_csel = m_body[1];
            for (int k = 1; k <= 5; k++) begin
              val = 0;
              for (int j = 0; j < 5; j++) val = val * 2 + int'(m_body[2 + 5 * (k - 1) + j]);
              m_o[k] = val[4:0];
            end
            m_fin = 1; m_err = 0;
          end else begin
            m_err = 1;
          end
          m_busy = 0; m_body.delete(); m_hist.delete();
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [29:0] a, x;
    if (chk_on) begin
      a = {out_sel, clk_sel, out1, out2, out3, out4, out5, finished, err, busy};
      x = {m_osel, m_csel, m_o[1], m_o[2], m_o[3], m_o[4], m_o[5], m_fin, m_err, m_busy};
      total++;
      if (a !== x) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, a, x);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit b);
    rst = r; en = e; din = b;
    @(posedge clk);
    model_update(r, e, b);
    @(negedge clk);
  endtask

  // mode 0: en always 1; mode 1: en alternates 1/0; mode 2: random idle gaps.
  task automatic send_bit(input bit b, input int mode);
    case (mode)
      0: step(1, 1, b);
      1: begin step(1, 1, b); step(1, 0, 1'($urandom_range(1, 0))); end
      default: begin
        repeat ($urandom_range(2, 0)) step(1, 0, 1'($urandom_range(1, 0)));
        step(1, 1, b);
      end
    endcase
  endtask

  task automatic send_frame(input logic [26:0] body, input bit badp, input int mode);
    logic [4:0] s;
    s = SYNC;
    for (int i = 4; i >= 0; i--) send_bit(s[i], mode);
    for (int i = 26; i >= 0; i--) send_bit(body[i], mode);
    if (PAR) send_bit(^body ^ badp, mode);
  endtask

  function automatic logic [26:0] mk(input bit os, input bit cs, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c,
                                     input logic [4:0] d, input logic [4:0] e);
    return {os, cs, a, b, c, d, e};
  endfunction

  task automatic reset_dut();
    step(0, 1, 1); step(0, 0, 0);
  endtask

  initial begin
    logic [26:0] ref_body, body;
    logic [4:0]  s;
    rst = 0; en = 0; din = 0;
    model_reset();
    reset_dut();
    chk_on = 1;

    chk("reset_outputs", {out_sel, clk_sel, out1, out2, out3, out4, out5, finished, err, busy}, 32'd0);

    ref_body = mk(1, 0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5);

    if (PAR) begin
      send_frame(ref_body, 1, 0);
      chk("badpar_out1", out1, 0);
      chk("badpar_finished", finished, 0);
      chk("badpar_err", err, 1);
      chk("badpar_busy", busy, 0);
    end

    send_frame(ref_body, 0, 0);
    chk("good_out_sel", out_sel, 1);
    chk("good_clk_sel", clk_sel, 0);
    chk("good_out1", out1, 1);
    chk("good_out2", out2, 2);
    chk("good_out3", out3, 3);
    chk("good_out4", out4, 4);
    chk("good_out5", out5, 5);
    chk("good_finished", finished, 1);
    chk("good_err", err, 0);
    chk("good_busy", busy, 0);

    send_frame(27'd0, 0, 0);
    chk("zero_outs", {out_sel, clk_sel, out1, out2, out3, out4, out5}, 0);
    chk("zero_finished", finished, 1);

    // Reset landing on body bit 12 drops the partial frame.
    reset_dut();
    s = SYNC;
    for (int i = 4; i >= 0; i--) send_bit(s[i], 0);
    for (int i = 26; i >= 16; i--) send_bit(ref_body[i], 0);
    step(0, 1, ref_body[15]);
    chk("midrst_outs", {out_sel, clk_sel, out1, out2, out3, out4, out5, finished, busy}, 0);
    send_frame(ref_body, 0, 0);
    chk("midrst_out3", out3, 3);
    chk("midrst_finished", finished, 1);

    reset_dut();
    send_frame(ref_body, 0, 1);
    chk("toggle_out5", out5, 5);
    chk("toggle_out_sel", out_sel, 1);
    chk("toggle_finished", finished, 1);

    // Sync pattern embedded in the body must be treated as data.
    body = mk(0, 1, 5'd7, 5'b10110, 5'b10110, 5'd9, 5'd31);
    send_frame(body, 0, 0);
    chk("embsync_out2", out2, 5'b10110);
    chk("embsync_out3", out3, 5'b10110);
    chk("embsync_out5", out5, 31);
    chk("embsync_clk_sel", clk_sel, 1);
    chk("embsync_busy", busy, 0);

    // Randomized traffic: garbage, resets, corrupt parity, mixed enable patterns.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(9, 0) == 0) step(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      repeat ($urandom_range(6, 0)) step(1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      body = 27'($urandom);
      send_frame(body, ($urandom_range(3, 0) == 0), $urandom_range(2, 0));
    end
    repeat (40) step(1, 1, 1'($urandom_range(1, 0)));

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sipo_rx.md
FRAME_SIPO_RX -- requirements
Module: frame_sipo_rx

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 5'b10110, 5-bit frame-start pattern searched in the serial stream.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port en, input, 1, bit-enable; the serial bit is sampled only on edges with en=1.
REQ-005 SHALL have port in, input, 1, serial configuration data, MSB first.
REQ-006 SHALL have port out_sel, output, 1, received output-mux select.
REQ-007 SHALL have port clk_sel, output, 1, received clock-source select.
REQ-008 SHALL have ports out1..out5, output, 5 each, received FSM jump targets.
REQ-009 SHALL have port finished, output, 1, high once at least one valid frame has been accepted.
REQ-010 SHALL have port err, output, 1, high after a frame failed its parity check.
REQ-011 SHALL have port busy, output, 1, high while a frame body is being received.

Function
REQ-012 SHALL implement states HUNT, LOAD, CHECK; en=0 edges SHALL leave every register unchanged.
REQ-013 HUNT: SHALL shift in into a 5-bit history; when {hist[3:0],in}==SYNC_WORD on an enabled edge, SHALL enter LOAD with bit count 0 and busy=1.
REQ-014 LOAD: SHALL shift 27 body bits into a shadow register, order out_sel, clk_sel, out1[4:0], out2, out3, out4, out5 (each MSB first).
REQ-015 Sync matching SHALL be suspended in LOAD and CHECK; a sync pattern inside the body is data.
REQ-016 After the 27th body bit, SHALL enter CHECK; the next enabled bit is the parity bit.
REQ-017 Parity SHALL be even: XOR of the 27 body bits and the parity bit equals 0.
REQ-018 On the edge sampling a good parity bit: outputs SHALL load from the shadow atomically, finished=1, err=0, busy=0, state HUNT.
REQ-019 On a bad parity bit: outputs SHALL hold previous values, err=1, finished unchanged, busy=0, state HUNT.
REQ-020 Outputs SHALL never show partial frames; they change only per REQ-018.
REQ-021 finished SHALL remain 1 until reset; subsequent good frames overwrite outputs with finished staying 1.
REQ-022 History SHALL be cleared on every return to HUNT; a new sync needs 5 fresh enabled bits.
REQ-023 Latency: outputs valid after the edge sampling the final frame bit; frame = 5 sync + 27 body + 1 parity = 33 enabled edges.

Reset
REQ-024 rst=0 at any rising edge SHALL force HUNT, clear history, count, and shadow, and set out_sel, clk_sel, out1..out5, finished, err, busy to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; outputs SHALL stay 0 until a complete valid frame arrives.
REQ-026 rst SHALL take priority over en.

Configuration
REQ-027 Macro FRAME_PARITY_EN: when defined, SHALL include the CHECK state and parity bit per REQ-016..019.
REQ-028 Without FRAME_PARITY_EN: frame SHALL be 32 bits; outputs SHALL commit on the 27th body bit edge; err SHALL be tied 0.

Verification
REQ-029 Reset, en=1, send 10110 + body 1,0,00001,00010,00011,00100,00101 + parity 0 -> after edge 33: out_sel=1, clk_sel=0, out1..5=1,2,3,4,5, finished=1, err=0.
REQ-030 Same frame with parity 1 -> outputs remain 0, finished=0, err=1, busy=0.
REQ-031 Good frame, then all-zero body frame with parity 0 -> outputs all 0, finished=1, err=0.
REQ-032 rst=0 at body bit 12, then full good frame -> outputs 0 until the good frame's last bit, then correct values.
REQ-033 en toggled 1/0 every cycle during a good frame -> same result as REQ-029, after 66 clocks.
REQ-034 Body containing 10110 in out2/out3 positions -> no resync; frame decoded correctly.
